// File: rtl/video_mux_pkg.sv
// Shared types and constants for the N-input video stream mux.
package video_mux_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        PASS = 1'b1
    } mux_state_t;

    // Start-of-frame flag position within tuser.
    localparam int SOF_BIT     = 0;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/axi_stream_reg_slice.sv
// One-deep registered AXI4-Stream slice carrying tdata/tlast/tuser.
// Upstream ready is combinational from downstream ready, so a continuous
// downstream ready gives one beat per cycle with one cycle of latency.
module axi_stream_reg_slice #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tlast,
    input  logic          s_tuser,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          m_tuser
);

    assign s_tready = ~m_tvalid | m_tready;

    // Load a new beat whenever the stage is empty or being emptied; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tlast <= s_tlast;
                m_tuser <= s_tuser;
            end
        end
    end

endmodule

// File: rtl/axi_stream_video_mux_n.sv
// N-input AXI4-Stream video mux that only changes source on a frame boundary.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   SEEK  | no frame in progress; follow req, drop non-SOF beats, wait for SOF
//   PASS  | forwarding a frame from active_sel_o; switch away at the next SOF
module axi_stream_video_mux_n
    import video_mux_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int DW    = 32,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                   axi_clk_i,
    input  logic                   axi_rst_i,
    input  logic [N_IN*DW-1:0]     s_tdata_i,
    input  logic [N_IN-1:0]        s_tvalid_i,
    output logic [N_IN-1:0]        s_tready_o,
    input  logic [N_IN-1:0]        s_tlast_i,
    input  logic [N_IN-1:0]        s_tuser_i,
    output logic [DW-1:0]          m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic                   m_tuser_o,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic                   drain_unsel_i,
    output logic [SEL_W-1:0]       active_sel_o,
    output logic                   switch_pending_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   sel_err_o,
    input  logic                   sel_err_clr_i
);

    // One extra bit so the range check is a real compare for any N_IN.
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_IN);

    mux_state_t              state_q;
    logic [SEL_W-1:0]        active_sel_q;
    logic [SEL_W-1:0]        req_q;
    logic [SEL_W-1:0]        req;
    logic [SEL_W-1:0]        cur;
    logic                    sel_ok;
    logic                    pending;
    logic [DW-1:0]           in_data [N_IN];
    logic [DW-1:0]           a_data;
    logic                    a_valid;
    logic                    a_last;
    logic [0:0]              a_user;
    logic                    a_sof;
    logic                    a_ready;
    logic                    fwd_valid;
    logic                    slice_ready;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q;
    logic                    sel_err_q;

    // Out-of-range selects are ignored; the last good request stays in force.
    always_comb begin
        sel_ok = {1'b0, sel_i} < N_LIM;
        req    = sel_ok ? sel_i : req_q;
    end

    // In SEEK the requested input is looked at directly so a retarget takes
    // effect without waiting for active_sel_q to catch up.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            in_data[k] = s_tdata_i[k*DW +: DW];
        end
        cur     = (state_q == SEEK) ? req : active_sel_q;
        a_data  = in_data[cur];
        a_valid = s_tvalid_i[cur];
        a_last  = s_tlast_i[cur];
        a_user  = s_tuser_i[cur];
        a_sof   = a_user[SOF_BIT];
        pending = (state_q == PASS) && (req != active_sel_q);
    end

    // Steer the active input: drop leading non-SOF beats in SEEK, and refuse
    // the next SOF in PASS when a switch is pending so the frame ends cleanly.
    always_comb begin
        fwd_valid = 1'b0;
        a_ready   = 1'b0;
        if (state_q == SEEK) begin
            if (a_sof) begin
                fwd_valid = a_valid;
                a_ready   = slice_ready;
            end else begin
                a_ready   = 1'b1;
            end
        end else if (!(pending && a_sof)) begin
            fwd_valid = a_valid;
            a_ready   = slice_ready;
        end
    end

    // Ready fan-out: active input gets the steered ready, others drain or hold.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            s_tready_o[k] = (SEL_W'(k) == cur) ? a_ready : drain_unsel_i;
        end
    end

    // Frame-boundary source switching FSM.
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state_q      <= SEEK;
            active_sel_q <= '0;
            req_q        <= '0;
        end else begin
            req_q <= req;
            case (state_q)
                SEEK: begin
                    active_sel_q <= req;
                    if (a_valid && a_sof && slice_ready) begin
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (pending && a_valid && a_sof) begin
                        state_q      <= SEEK;
                        active_sel_q <= req;
                    end
                end
                default: state_q <= SEEK;
            endcase
        end
    end

    // Sticky select-error flag; a new error wins over a simultaneous clear.
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            sel_err_q <= 1'b0;
        end else if (!sel_ok) begin
            sel_err_q <= 1'b1;
        end else if (sel_err_clr_i) begin
            sel_err_q <= 1'b0;
        end
    end

    // Count SOF beats handed to the downstream consumer; wraps naturally.
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            frame_cnt_q <= '0;
        end else if (m_tvalid_o && m_tready_i && m_tuser_o) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    axi_stream_reg_slice #(.DW(DW)) u_out_slice (
        .clk      (axi_clk_i),
        .rst      (axi_rst_i),
        .s_tdata  (a_data),
        .s_tvalid (fwd_valid),
        .s_tready (slice_ready),
        .s_tlast  (a_last),
        .s_tuser  (a_sof),
        .m_tdata  (m_tdata_o),
        .m_tvalid (m_tvalid_o),
        .m_tready (m_tready_i),
        .m_tlast  (m_tlast_o),
        .m_tuser  (m_tuser_o)
    );

    assign active_sel_o     = active_sel_q;
    assign switch_pending_o = pending;
    assign frame_cnt_o      = frame_cnt_q;
    assign sel_err_o        = sel_err_q;

endmodule

// File: tb/tb_axi_stream_video_mux_n.sv
// Scoreboard bench for axi_stream_video_mux_n. Five inputs so that a select
// value of 5 is representable and out of range.
module tb_axi_stream_video_mux_n;
    import video_mux_pkg::*;

    localparam int N_IN  = 5;
    localparam int DW    = 32;
    localparam int SEL_W = $clog2(N_IN);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_IN*DW-1:0]   s_tdata;
    logic [N_IN-1:0]      s_tvalid, s_tready, s_tlast, s_tuser;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid, m_tready, m_tlast, m_tuser;
    logic [SEL_W-1:0]     sel, active_sel;
    logic                 drain, pending, sel_err, sel_err_clr;
    logic [15:0]          frame_cnt;

    logic [DW-1:0] src_data  [N_IN];
    logic          src_valid [N_IN];
    logic          src_last  [N_IN];
    logic          src_user  [N_IN];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    beat_t exp_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    bit    prev_stall = 0;
    beat_t held;
    bit    done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            s_tdata[k*DW +: DW] = src_data[k];
            s_tvalid[k]         = src_valid[k];
            s_tlast[k]          = src_last[k];
            s_tuser[k]          = src_user[k];
        end
    end

    axi_stream_video_mux_n #(.N_IN(N_IN), .DW(DW)) dut (
        .axi_clk_i        (clk),
        .axi_rst_i        (rst),
        .s_tdata_i        (s_tdata),
        .s_tvalid_i       (s_tvalid),
        .s_tready_o       (s_tready),
        .s_tlast_i        (s_tlast),
        .s_tuser_i        (s_tuser),
        .m_tdata_o        (m_tdata),
        .m_tvalid_o       (m_tvalid),
        .m_tready_i       (m_tready),
        .m_tlast_o        (m_tlast),
        .m_tuser_o        (m_tuser),
        .sel_i            (sel),
        .drain_unsel_i    (drain),
        .active_sel_o     (active_sel),
        .switch_pending_o (pending),
        .frame_cnt_o      (frame_cnt),
        .sel_err_o        (sel_err),
        .sel_err_clr_i    (sel_err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one beat on input k, wait (bounded) for acceptance, and queue
    // the expected output beat if it should be forwarded.
    task automatic send_beat(input int k, input logic [31:0] d, input logic l,
                             input logic u, input bit fwd);
        bit ok = 0;
        src_data[k]  = d;
        src_last[k]  = l;
        src_user[k]  = u;
        src_valid[k] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_tready[k]) begin
                ok = 1;
                break;
            end
        end
        if (ok && fwd) exp_q.push_back('{d: d, l: l, u: u});
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: input %0d beat %0h not accepted within 50 cycles", k, d);
        end
        @(posedge clk);
        #1;
        src_valid[k] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output handshake; check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_tvalid}, 32'd1);
                check("stall_stable", {m_tdata[29:0], m_tlast, m_tuser}, {held.d[29:0], held.l, held.u});
            end
            if (m_tvalid && m_tready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_beat: got data %0h last %0b user %0b, required no beat",
                             m_tdata, m_tlast, m_tuser);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if ({m_tdata, m_tlast, m_tuser} !== e) begin
                        mismatched++;
                        $display("FAIL out_beat: got %0h/%0b/%0b required %0h/%0b/%0b",
                                 m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            held       = '{d: m_tdata, l: m_tlast, u: m_tuser};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_tready = 1'b1; sel = '0; drain = 1'b0; sel_err_clr = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            src_data[k] = '0; src_valid[k] = 1'b0; src_last[k] = 1'b0; src_user[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_active", {29'd0, active_sel}, 32'd0);
        check("rst_sel_err", {31'd0, sel_err}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);

        // Test 1: leading non-SOF beats dropped, then 2x4 frame on input0
        for (int i = 0; i < 3; i++) send_beat(0, 32'h0000_0010 + i, 1'b0, 1'b0, 1'b0);
        check("drop_no_valid", {31'd0, m_tvalid}, 32'd0);
        send_beat(0, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
        check("latency_valid", {31'd0, m_tvalid}, 32'd1);
        check("latency_user", {31'd0, m_tuser}, 32'd1);
        check("latency_data", m_tdata, 32'h0000_0100);
        begin
            int t0;
            t0 = cyc;
            for (int i = 1; i < 8; i++)
                send_beat(0, 32'h0000_0100 + i, (i == 3) || (i == 7), 1'b0, 1'b1);
            check("throughput_cycles", cyc - t0, 32'd7);
        end
        tick();
        check("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);

        // Test 2: request input2 mid-frame; input0 frame completes, its next SOF refused
        send_beat(0, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
        send_beat(0, 32'h0000_0201, 1'b0, 1'b0, 1'b1);
        sel = 3'd2;
        #1;
        check("pending_set", {31'd0, pending}, 32'd1);
        check("active_still_0", {29'd0, active_sel}, 32'd0);
        send_beat(0, 32'h0000_0202, 1'b0, 1'b0, 1'b1);
        send_beat(0, 32'h0000_0203, 1'b1, 1'b0, 1'b1);
        src_data[0] = 32'h0000_0300; src_user[0] = 1'b1; src_last[0] = 1'b0; src_valid[0] = 1'b1;
        @(negedge clk);
        check("old_sof_refused", {31'd0, s_tready[0]}, 32'd0);
        tick();
        check("active_now_2", {29'd0, active_sel}, 32'd2);
        check("pending_clear", {31'd0, pending}, 32'd0);
        src_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(2, 32'h0000_0400 + i, i == 3, i == 0, 1'b1);

        // Test 3: output ready toggling every cycle during a frame
        done = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(2, 32'h0000_0500 + i, i == 5, i == 0, 1'b1);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_tready = ~m_tready;
                end
            end
        join
        m_tready = 1'b1;

        // Test 4: drain vs hold for unselected input1 while input2 streams
        drain = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send_beat(2, 32'h0000_0600 + i, i == 3, i == 0, 1'b1);
            for (int i = 0; i < 6; i++) begin
                src_data[1] = 32'h0000_0700 + i; src_user[1] = (i == 0);
                src_last[1] = 1'b0; src_valid[1] = 1'b1;
                @(negedge clk);
                check("drain_ready", {31'd0, s_tready[1]}, 32'd1);
                tick();
            end
        join
        drain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ready", {31'd0, s_tready[1]}, 32'd0);
            tick();
        end
        src_valid[1] = 1'b0;
        repeat (3) tick();
        check("frame_cnt_5", {16'd0, frame_cnt}, 32'd5);

        // Test 5: move to input1, then out-of-range select and error flag
        sel = 3'd1;
        src_data[2] = 32'h0000_0800; src_user[2] = 1'b1; src_last[2] = 1'b0; src_valid[2] = 1'b1;
        @(negedge clk);
        check("sof2_refused", {31'd0, s_tready[2]}, 32'd0);
        tick();
        src_valid[2] = 1'b0;
        check("active_now_1", {29'd0, active_sel}, 32'd1);
        sel = 3'd5;
        tick();
        check("sel_err_set", {31'd0, sel_err}, 32'd1);
        check("active_stays_1", {29'd0, active_sel}, 32'd1);
        sel = 3'd1; sel_err_clr = 1'b1;
        tick();
        sel_err_clr = 1'b0;
        check("sel_err_cleared", {31'd0, sel_err}, 32'd0);
        sel = 3'd5; sel_err_clr = 1'b1;
        tick();
        sel = 3'd1; sel_err_clr = 1'b0;
        check("sel_err_set_wins", {31'd0, sel_err}, 32'd1);

        // Test 6: reset while a beat is stalled in the output register
        m_tready = 1'b0;
        send_beat(1, 32'h0000_0900, 1'b0, 1'b1, 1'b0);
        check("stalled_valid", {31'd0, m_tvalid}, 32'd1);
        sel = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst2_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst2_active", {29'd0, active_sel}, 32'd0);
        check("rst2_state_seek", {31'd0, dut.state_q == SEEK}, 32'd1);
        check("rst2_sel_err", {31'd0, sel_err}, 32'd0);
        m_tready = 1'b1;

        // Test 7: frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        check("cnt_preload", {16'd0, frame_cnt}, 32'h0000_FFFF);
        send_beat(0, 32'h0000_0A00, 1'b1, 1'b1, 1'b1);
        tick();
        check("cnt_wrap", {16'd0, frame_cnt}, 32'd0);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
